cordic_phase_gen: RTL and testbench

NCO front/back-end wrapped around the iterative CORDIC core. On each sample strobe it advances a phase accumulator, folds the phase into the core's convergence range (±π/2), and issues one rotation request. When the core signals completion, it applies the quadrant correction and presents registered `cos_o`/`sin_o`. It sits directly upstream of the CORDIC core, driving its `x`/`y`/`z` inputs and start strobe, and directly downstream, consuming its `x`/`y` results and done strobe.

---
 rtl/cordic_phase_gen_pkg.sv | 15 +
 rtl/cordic_quadrant_fold.sv | 14 +
 rtl/cordic_phase_gen.sv | 103 ++++++++++
 tb/tb_cordic_phase_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_phase_gen_pkg.sv
// Shared constants and state type for the CORDIC NCO wrapper and related blocks.
package cordic_phase_gen_pkg;

  localparam int unsigned ANGLE_PI     = 128;  // angle code for pi at 7 fractional bits
  localparam int unsigned DEF_N_FRAC   = 7;
  localparam int          DEF_X_INIT   = 77;   // 2^7 / 1.6468
  localparam int unsigned ITERATIONS   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Folds a full-circle angle into the CORDIC convergence range (+/- pi/2).
module cordic_quadrant_fold #(
  parameter int unsigned N_FRAC = 7
) (
  input  logic [N_FRAC:0] i_p,
  output logic [N_FRAC:0] o_z,
  output logic            o_flip
);

  // Top two bits equal means p already lies in [-pi/2, pi/2).
  assign o_flip = i_p[N_FRAC] ^ i_p[N_FRAC-1];
  assign o_z    = o_flip ? {~i_p[N_FRAC], i_p[N_FRAC-1:0]} : i_p;

endmodule

// File: rtl/cordic_phase_gen.sv
// NCO front/back-end: phase accumulator, quadrant fold, one rotation request per
// sample, and quadrant correction of the core's result.
module cordic_phase_gen
  import cordic_phase_gen_pkg::*;
#(
  parameter int unsigned N_FRAC   = DEF_N_FRAC,
  parameter int unsigned BW_PHASE = 16,
  parameter int          X_INIT   = DEF_X_INIT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sample_strobe_i,
  input  logic [BW_PHASE-1:0] phase_inc_i,
  output logic [N_FRAC:0]     cordic_x_o,
  output logic [N_FRAC:0]     cordic_y_o,
  output logic [N_FRAC:0]     cordic_z_o,
  output logic                cordic_valid_strobe_o,
  input  logic [N_FRAC:0]     cordic_x_i,
  input  logic [N_FRAC:0]     cordic_y_i,
  input  logic                cordic_valid_strobe_i,
  output logic [N_FRAC:0]     cos_o,
  output logic [N_FRAC:0]     sin_o,
  output logic                sample_valid_strobe_o,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam int unsigned W = N_FRAC + 1;
  localparam logic [N_FRAC:0] MOST_NEG = {1'b1, {N_FRAC{1'b0}}};
  localparam logic [N_FRAC:0] MOST_POS = {1'b0, {N_FRAC{1'b1}}};

  state_t              r_state;
  logic [BW_PHASE-1:0] r_phase_acc;
  logic                r_flip;

  logic [N_FRAC:0] w_p;
  logic [N_FRAC:0] w_z;
  logic            w_flip;
  logic [N_FRAC:0] w_neg_x;
  logic [N_FRAC:0] w_neg_y;

  assign w_p = r_phase_acc[BW_PHASE-1 -: W];

  cordic_quadrant_fold #(.N_FRAC(N_FRAC)) u_fold (
    .i_p    (w_p),
    .o_z    (w_z),
    .o_flip (w_flip)
  );

  always_comb begin
    w_neg_x = (cordic_x_i == MOST_NEG) ? MOST_POS : W'(-cordic_x_i);
    w_neg_y = (cordic_y_i == MOST_NEG) ? MOST_POS : W'(-cordic_y_i);
  end

  assign busy_o = (r_state != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state               <= ST_IDLE;
      r_phase_acc           <= '0;
      r_flip                <= 1'b0;
      cordic_x_o            <= '0;
      cordic_y_o            <= '0;
      cordic_z_o            <= '0;
      cordic_valid_strobe_o <= 1'b0;
      cos_o                 <= '0;
      sin_o                 <= '0;
      sample_valid_strobe_o <= 1'b0;
      overrun_o             <= 1'b0;
    end else begin
      cordic_valid_strobe_o <= 1'b0;
      sample_valid_strobe_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sample_strobe_i) begin
            r_phase_acc           <= r_phase_acc + phase_inc_i;
            r_flip                <= w_flip;
            cordic_x_o            <= W'(X_INIT);
            cordic_y_o            <= '0;
            cordic_z_o            <= w_z;
            cordic_valid_strobe_o <= 1'b1;
            r_state               <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sample_strobe_i) overrun_o <= 1'b1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sample_strobe_i) overrun_o <= 1'b1;
          if (cordic_valid_strobe_i) begin
            cos_o                 <= r_flip ? w_neg_x : cordic_x_i;
            sin_o                 <= r_flip ? w_neg_y : cordic_y_i;
            sample_valid_strobe_o <= 1'b1;
            r_state               <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench for cordic_phase_gen with a hand-driven stub core.
module tb_cordic_phase_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic [15:0] inc;
  logic [7:0]  cx_o, cy_o, cz_o;
  logic        cvalid_o;
  logic [7:0]  cx_i, cy_i;
  logic        cdone;
  logic [7:0]  cos_w, sin_w;
  logic        svalid, busy, ovr;

  int checks = 0;
  int passed = 0;
  int unsigned model_acc = 0;

  always #5 clk = ~clk;

  cordic_phase_gen #(.N_FRAC(7), .BW_PHASE(16), .X_INIT(77)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .sample_strobe_i       (strobe),
    .phase_inc_i           (inc),
    .cordic_x_o            (cx_o),
    .cordic_y_o            (cy_o),
    .cordic_z_o            (cz_o),
    .cordic_valid_strobe_o (cvalid_o),
    .cordic_x_i            (cx_i),
    .cordic_y_i            (cy_i),
    .cordic_valid_strobe_i (cdone),
    .cos_o                 (cos_w),
    .sin_o                 (sin_w),
    .sample_valid_strobe_o (svalid),
    .busy_o                (busy),
    .overrun_o             (ovr)
  );

  typedef struct {
    logic [15:0] inc;
    bit          echo;
    int          sx;
    int          sy;
    int          dly;
    int          exp_z;
    int          exp_cos;
    int          exp_sin;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic int s8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Reference: angle from the pre-increment accumulator, folded by half-turn.
  function automatic void ref_fold(input int unsigned acc, output int z, output bit flip);
    int p;
    p = int'(acc >> 8);
    if (p >= 128) p -= 256;
    if (p >= -64 && p <= 63) begin
      z = p; flip = 0;
    end else begin
      z = (p < 0) ? p + 128 : p - 128; flip = 1;
    end
  endfunction

  function automatic int ref_out(input int v, input bit flip);
    int n;
    if (!flip) return v;
    n = -v;
    return (n > 127) ? 127 : n;
  endfunction

  // One sample: strobe, check request, stub reply after dly cycles, check result.
  // ovr_mode 1: extra strobe in first WAIT cycle; 2: strobe together with done.
  task automatic run_sample(input string name, input logic [15:0] i_inc, input bit echo,
                            input int sx, input int sy, input int dly, input int ovr_mode,
                            input int exp_z, input int exp_cos, input int exp_sin);
    int xr;
    strobe = 1'b1; inc = i_inc;
    tick();
    strobe = 1'b0; inc = $urandom_range(0, 65535);
    chk({name, ".start"}, int'(cvalid_o), 1);
    chk({name, ".busy"},  int'(busy), 1);
    chk({name, ".z"},     s8(cz_o), exp_z);
    chk({name, ".x"},     s8(cx_o), 77);
    chk({name, ".y"},     s8(cy_o), 0);
    tick();
    chk({name, ".start_end"}, int'(cvalid_o), 0);
    if (ovr_mode == 1) begin
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      dly = (dly > 1) ? dly - 1 : 1;
    end
    for (int i = 1; i < dly; i++) begin
      tick();
      if (svalid) chk({name, ".early_valid"}, int'(svalid), 0);
    end
    xr = echo ? s8(cz_o) : sx;
    cx_i = 8'(xr); cy_i = 8'(sy); cdone = 1'b1;
    if (ovr_mode == 2) strobe = 1'b1;
    tick();
    cdone = 1'b0; strobe = 1'b0;
    cx_i = 8'($urandom_range(0, 255)); cy_i = 8'($urandom_range(0, 255));
    chk({name, ".valid"}, int'(svalid), 1);
    chk({name, ".busy_done"}, int'(busy), 0);
    chk({name, ".cos"}, s8(cos_w), exp_cos);
    chk({name, ".sin"}, s8(sin_w), exp_sin);
    tick();
    chk({name, ".valid_end"}, int'(svalid), 0);
    chk({name, ".cos_hold"}, s8(cos_w), exp_cos);
    model_acc = (model_acc + i_inc) & 32'hFFFF;
  endtask

  vec_t vecs[6];

  initial begin
    int z, c, s, x, y, d;
    bit f;

    vecs[0] = '{16'h2000, 1'b1, 0, 0, 3, 0, 0, 0};
    vecs[1] = '{16'h2000, 1'b1, 0, 0, 3, 32, 32, 0};
    vecs[2] = '{16'h2000, 1'b1, 0, 0, 3, -64, 64, 0};
    vecs[3] = '{16'h2000, 1'b1, 0, 0, 3, -32, 32, 0};
    vecs[4] = '{16'hE400, 1'b0, -128, 5, 4, 0, 127, -5};
    vecs[5] = '{16'h0000, 1'b0, 100, 20, 8, -28, -100, -20};

    rst = 1'b1; strobe = 1'b0; inc = '0; cx_i = '0; cy_i = '0; cdone = 1'b0;
    tick(); tick();
    chk("rst.cos", s8(cos_w), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.ovr", int'(ovr), 0);
    chk("rst.start", int'(cvalid_o), 0);
    rst = 1'b0;
    tick();

    cdone = 1'b1; cx_i = 8'd9;
    tick();
    cdone = 1'b0;
    tick();
    chk("idle_done.valid", int'(svalid), 0);
    chk("idle_done.busy", int'(busy), 0);

    foreach (vecs[i])
      run_sample($sformatf("vec%0d", i), vecs[i].inc, vecs[i].echo, vecs[i].sx, vecs[i].sy,
                 vecs[i].dly, 0, vecs[i].exp_z, vecs[i].exp_cos, vecs[i].exp_sin);
    chk("ovr_clear", int'(ovr), 0);

    for (int n = 0; n < 24; n++) begin
      inc = 16'($urandom_range(0, 65535));
      x = $urandom_range(0, 255) - 128;
      y = $urandom_range(0, 255) - 128;
      if (n % 6 == 0) x = -128;
      d = $urandom_range(1, 9);
      ref_fold(model_acc, z, f);
      c = ref_out(x, f);
      s = ref_out(y, f);
      run_sample($sformatf("rnd%0d", n), inc, 1'b0, x, y, d, 0, z, c, s);
    end

    ref_fold(model_acc, z, f);
    run_sample("ovr_wait", 16'h0700, 1'b0, 10, -10, 4, 1, z, ref_out(10, f), ref_out(-10, f));
    chk("ovr_set", int'(ovr), 1);
    ref_fold(model_acc, z, f);
    run_sample("ovr_done", 16'h0300, 1'b0, 3, 4, 2, 2, z, ref_out(3, f), ref_out(4, f));
    ref_fold(model_acc, z, f);
    run_sample("after_ovr", 16'h0000, 1'b0, 1, 2, 2, 0, z, ref_out(1, f), ref_out(2, f));
    chk("ovr_sticky", int'(ovr), 1);

    strobe = 1'b1; inc = 16'h1111;
    tick();
    strobe = 1'b0;
    tick(); tick();
    chk("mid.busy", int'(busy), 1);
    rst = 1'b1;
    #2;
    chk("mrst.busy", int'(busy), 0);
    chk("mrst.cos", s8(cos_w), 0);
    chk("mrst.sin", s8(sin_w), 0);
    chk("mrst.z", s8(cz_o), 0);
    chk("mrst.x", s8(cx_o), 0);
    chk("mrst.ovr", int'(ovr), 0);
    tick();
    rst = 1'b0;
    model_acc = 0;
    cdone = 1'b1; cx_i = 8'd50; cy_i = 8'd50;
    tick();
    cdone = 1'b0;
    chk("late_done.valid", int'(svalid), 0);
    tick();
    chk("late_done.valid2", int'(svalid), 0);
    chk("late_done.cos", s8(cos_w), 0);
    run_sample("post_rst", 16'h4000, 1'b1, 0, 0, 2, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
